// File: rtl/booth_ctrl.sv
// booth_ctrl: control unit for a radix-2 Booth sequential multiplier.
// Sequences an external A/Q/q-1/M datapath through N test/shift iterations.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   start      level request; held high until fin is seen
//   q0, q_1    Booth pair {Q[0], q-1}, examined only in TEST
//   cargaQ     load Q from the multiplier operand and clear q-1
//   cargaM     load M from the multiplicand operand
//   limpiaA    clear accumulator A
//   cargaA     load A with the adder/subtractor result
//   restaA     adder mode (1 = A-M, 0 = A+M), meaningful while cargaA=1
//   desplazaQ  arithmetic right shift of A:Q:q-1
//   busy       operation in progress (all states except IDLE and DONE)
//   fin        product valid in A:Q
module booth_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic q_1,
  output logic cargaQ,
  output logic cargaM,
  output logic limpiaA,
  output logic cargaA,
  output logic restaA,
  output logic desplazaQ,
  output logic busy,
  output logic fin
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // State-only outputs are registered: each branch sets the values that
  // belong to the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cargaQ    <= 1'b0;
      cargaM    <= 1'b0;
      limpiaA   <= 1'b0;
      desplazaQ <= 1'b0;
      busy      <= 1'b0;
      fin       <= 1'b0;
    end else begin
      cargaQ    <= 1'b0;
      cargaM    <= 1'b0;
      limpiaA   <= 1'b0;
      desplazaQ <= 1'b0;
      busy      <= 1'b0;
      fin       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            cargaQ  <= 1'b1;
            cargaM  <= 1'b1;
            limpiaA <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= TEST;
          busy  <= 1'b1;
        end
        TEST: begin
          state     <= SHIFT;
          desplazaQ <= 1'b1;
          busy      <= 1'b1;
        end
        SHIFT: begin
          // Counter holds at N-1 on the final pass so it can never wrap,
          // even when N is a power of two.
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            fin   <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= TEST;
            busy  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            fin <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The add/subtract decision must see the Booth pair of the current
  // iteration, which only settles once TEST is entered, so it is decoded
  // from the state register rather than registered.
  always_comb begin
    cargaA = 1'b0;
    restaA = 1'b0;
    if (state == TEST) begin
      cargaA = q0 ^ q_1;
      restaA = q0 & ~q_1;
    end
  end

endmodule

// File: tb/tb_booth_ctrl.sv
module tb_booth_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic st4, st2, st16;
  logic zero;

  logic cQ4, cM4, lA4, cA4, rA4, dQ4, b4, f4;
  logic cQ2, cM2, lA2, cA2, rA2, dQ2, b2, f2;
  logic cQ16, cM16, lA16, cA16, rA16, dQ16, b16, f16;

  // Datapath model for the N=4 instance
  logic [3:0] m_a, m_q, m_m;
  logic       m_q1;
  logic [3:0] mcand, mult;

  int checks;
  int failures;

  booth_ctrl #(.N(4)) u_d4 (
    .clk(clk), .reset(reset), .start(st4), .q0(m_q[0]), .q_1(m_q1),
    .cargaQ(cQ4), .cargaM(cM4), .limpiaA(lA4), .cargaA(cA4), .restaA(rA4),
    .desplazaQ(dQ4), .busy(b4), .fin(f4)
  );

  booth_ctrl #(.N(2)) u_d2 (
    .clk(clk), .reset(reset), .start(st2), .q0(zero), .q_1(zero),
    .cargaQ(cQ2), .cargaM(cM2), .limpiaA(lA2), .cargaA(cA2), .restaA(rA2),
    .desplazaQ(dQ2), .busy(b2), .fin(f2)
  );

  booth_ctrl #(.N(16)) u_d16 (
    .clk(clk), .reset(reset), .start(st16), .q0(zero), .q_1(zero),
    .cargaQ(cQ16), .cargaM(cM16), .limpiaA(lA16), .cargaA(cA16), .restaA(rA16),
    .desplazaQ(dQ16), .busy(b16), .fin(f16)
  );

  always @(posedge clk) begin
    if (cQ4) begin
      m_q  <= mult;
      m_q1 <= 1'b0;
    end
    if (cM4) m_m <= mcand;
    if (lA4) m_a <= '0;
    if (cA4) m_a <= rA4 ? (m_a - m_m) : (m_a + m_m);
    if (dQ4) {m_a, m_q, m_q1} <= {m_a[3], m_a, m_q};
  end

  function automatic logic [7:0] outs4();
    return {cQ4, cM4, lA4, cA4, rA4, dQ4, b4, f4};
  endfunction

  function automatic logic [7:0] outs2();
    return {cQ2, cM2, lA2, cA2, rA2, dQ2, b2, f2};
  endfunction

  function automatic logic [7:0] outs16();
    return {cQ16, cM16, lA16, cA16, rA16, dQ16, b16, f16};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one N=4 operation. Edge 0 is the edge that samples start=1 in
  // IDLE; returns the edge at which fin first reads high (-1 on timeout).
  task automatic run4(input logic [3:0] mc, input logic [3:0] ml,
                      input int drop_edge, output int fin_edge,
                      output logic [7:0] dec, output int n_add,
                      output int n_shift, output int n_bad);
    mcand    = mc;
    mult     = ml;
    dec      = '0;
    n_add    = 0;
    n_shift  = 0;
    n_bad    = 0;
    fin_edge = -1;
    st4      = 1'b1;
    tick();
    for (int e = 1; e <= 40; e++) begin
      if (e == drop_edge) st4 = 1'b0;
      tick();
      if (cA4) n_add++;
      if (dQ4) n_shift++;
      if (b4 && !cQ4 && !dQ4) dec = {dec[5:0], cA4, rA4};
      if ((int'(cQ4) + int'(cA4) + int'(dQ4)) > 1) n_bad++;
      if (f4) begin
        fin_edge = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    st4 = 1'b0; st2 = 1'b0; st16 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({outs4(), outs2(), outs16()} !== 24'h0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: got %h %h %h, want 00 00 00",
                 i, outs4(), outs2(), outs16());
      end
    end
  endtask

  task automatic test_positive();
    int fe, na, ns, nb;
    logic [7:0] dec;
    run4(4'd3, 4'b0110, 0, fe, dec, na, ns, nb);
    checks++;
    if (fe !== 9) begin
      failures++;
      $display("FAIL pos_latency: fin at edge %0d, want 9", fe);
    end
    checks++;
    if (dec !== 8'b00_11_00_10) begin
      failures++;
      $display("FAIL pos_decisions: got %b, want 00110010", dec);
    end
    checks++;
    if ({m_a, m_q} !== 8'd18) begin
      failures++;
      $display("FAIL pos_product: got %0d, want 18", {m_a, m_q});
    end
    st4 = 1'b0;
    tick();
    checks++;
    if (outs4() !== 8'h00) begin
      failures++;
      $display("FAIL pos_return_idle: got %h, want 00", outs4());
    end
  endtask

  task automatic test_negative();
    int fe, na, ns, nb;
    logic [7:0] dec;
    run4(4'b1101, 4'b1011, 0, fe, dec, na, ns, nb);
    checks++;
    if (fe !== 9) begin
      failures++;
      $display("FAIL neg_latency: fin at edge %0d, want 9", fe);
    end
    checks++;
    if (dec !== 8'b11_00_10_11) begin
      failures++;
      $display("FAIL neg_decisions: got %b, want 11001011", dec);
    end
    checks++;
    if ({m_a, m_q} !== 8'd15) begin
      failures++;
      $display("FAIL neg_product: got %0d, want 15", {m_a, m_q});
    end
    checks++;
    if (na !== 3) begin
      failures++;
      $display("FAIL neg_cargaA_count: got %0d, want 3", na);
    end
    checks++;
    if (ns !== 4) begin
      failures++;
      $display("FAIL neg_shift_count: got %0d, want 4", ns);
    end
    checks++;
    if (nb !== 0) begin
      failures++;
      $display("FAIL neg_exclusive: %0d overlap cycles, want 0", nb);
    end
    st4 = 1'b0;
    tick();
  endtask

  task automatic test_drop_start();
    int fe, na, ns, nb;
    logic [7:0] dec;
    run4(4'd3, 4'd5, 3, fe, dec, na, ns, nb);
    checks++;
    if (fe !== 9) begin
      failures++;
      $display("FAIL drop_latency: fin at edge %0d, want 9", fe);
    end
    checks++;
    if ({m_a, m_q} !== 8'd15) begin
      failures++;
      $display("FAIL drop_product: got %0d, want 15", {m_a, m_q});
    end
    st4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs4() !== 8'h01) begin
        failures++;
        $display("FAIL done_hold cycle %0d: got %h, want 01", i, outs4());
      end
    end
    st4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs4() !== 8'h00) begin
        failures++;
        $display("FAIL done_exit cycle %0d: got %h, want 00", i, outs4());
      end
    end
  endtask

  task automatic test_reset_midop();
    int fe, na, ns, nb;
    logic [7:0] dec;
    mcand = 4'd2;
    mult  = 4'd7;
    st4   = 1'b1;
    tick();
    for (int e = 1; e <= 4; e++) tick();
    reset = 1'b0;
    st4   = 1'b0;
    tick();
    checks++;
    if (outs4() !== 8'h00) begin
      failures++;
      $display("FAIL midop_reset_edge: got %h, want 00", outs4());
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs4() !== 8'h00) begin
        failures++;
        $display("FAIL midop_after_release cycle %0d: got %h, want 00", i, outs4());
      end
    end
    run4(4'd3, 4'b0110, 0, fe, dec, na, ns, nb);
    checks++;
    if (fe !== 9) begin
      failures++;
      $display("FAIL midop_restart_latency: fin at edge %0d, want 9", fe);
    end
    checks++;
    if ({m_a, m_q} !== 8'd18) begin
      failures++;
      $display("FAIL midop_restart_product: got %0d, want 18", {m_a, m_q});
    end
    st4 = 1'b0;
    tick();
  endtask

  task automatic test_widths();
    int fe, ns;
    fe = -1; ns = 0;
    st2 = 1'b1;
    tick();
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (dQ2) ns++;
      if (f2) begin
        fe = e;
        break;
      end
    end
    checks++;
    if (fe !== 5) begin
      failures++;
      $display("FAIL n2_latency: fin at edge %0d, want 5", fe);
    end
    checks++;
    if (ns !== 2) begin
      failures++;
      $display("FAIL n2_shifts: got %0d, want 2", ns);
    end
    st2 = 1'b0;
    tick();

    fe = -1; ns = 0;
    st16 = 1'b1;
    tick();
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (dQ16) ns++;
      if (f16) begin
        fe = e;
        break;
      end
    end
    checks++;
    if (fe !== 33) begin
      failures++;
      $display("FAIL n16_latency: fin at edge %0d, want 33", fe);
    end
    checks++;
    if (ns !== 16) begin
      failures++;
      $display("FAIL n16_shifts: got %0d, want 16", ns);
    end
    st16 = 1'b0;
    tick();
    checks++;
    if (outs16() !== 8'h00) begin
      failures++;
      $display("FAIL n16_return_idle: got %h, want 00", outs16());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    zero     = 1'b0;
    reset    = 1'b0;
    st4 = 1'b0; st2 = 1'b0; st16 = 1'b0;
    mcand = '0;
    mult  = '0;
    test_reset();
    test_positive();
    test_negative();
    test_drop_start();
    test_reset_midop();
    test_widths();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
